// File: rtl/items_reloader_pkg.sv
// Shared definitions for the item-map reloader.
//   - Maze grid dimensions and address/code widths
//   - Tile codes stored in the item RAM and delivered by the item-map ROM
//   - Controller state encoding
//   - is_edible(): true for tiles that count toward the remaining-item total
package items_reloader_pkg;

  localparam int unsigned GRID_W    = 28;
  localparam int unsigned GRID_H    = 31;
  localparam int unsigned GRID_SIZE = GRID_W * GRID_H;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned CODE_W    = 2;

  // First address past the grid; also the terminal value of the fill counter.
  localparam logic [ADDR_W-1:0] GRID_END = ADDR_W'(GRID_SIZE);

  typedef enum logic [CODE_W-1:0] {
    TILE_EMPTY     = 2'b00,
    TILE_DOT       = 2'b01,
    TILE_ENERGIZER = 2'b10,
    TILE_RSVD      = 2'b11   // behaves exactly like an empty tile
  } tile_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE,
    ST_ACTIVE
  } state_e;

  function automatic logic is_edible(input logic [CODE_W-1:0] code);
    return (code == TILE_DOT) || (code == TILE_ENERGIZER);
  endfunction

endpackage

// File: rtl/items_reloader_ram.sv
// Item storage: GRID_SIZE x CODE_W RAM.
//   Port A (i_a_*, o_a_rdata): synchronous write + synchronous read, used by
//     the fill sequencer and the eat read-modify-write.
//   Port B (i_b_addr, o_b_rdata): synchronous read for the renderer.
// Both reads are read-before-write: a read of a word written on the same edge
// returns the previous contents. Addresses past the grid read as empty and
// never write.
module items_ram
  import items_reloader_pkg::*;
(
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic              i_a_we,
  input  logic [CODE_W-1:0] i_a_wdata,
  output logic [CODE_W-1:0] o_a_rdata,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [CODE_W-1:0] o_b_rdata
);

  logic [CODE_W-1:0] mem_q [GRID_SIZE];
  logic [CODE_W-1:0] a_rdata_q;
  logic [CODE_W-1:0] b_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_a_we && (i_a_addr < GRID_END)) begin
      mem_q[i_a_addr] <= i_a_wdata;
    end
    a_rdata_q <= (i_a_addr < GRID_END) ? mem_q[i_a_addr] : TILE_EMPTY;
    b_rdata_q <= (i_b_addr < GRID_END) ? mem_q[i_b_addr] : TILE_EMPTY;
  end

  assign o_a_rdata = a_rdata_q;
  assign o_b_rdata = b_rdata_q;

endmodule

// File: rtl/items_reloader.sv
// Item-map reloader for the maze: copies the initial item map from ROM into
// a RAM on request, tracks the number of edible items left, and services
// pacman eat requests with a read-modify-write on that RAM.
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_items_reload / o_items_reload_done  level request / level completion
//   o_rom_addr, i_rom_data            item-map ROM, one-cycle read latency
//   i_eat_valid, i_eat_addr, o_eat_ready  eat request handshake
//   o_eaten_dot, o_eaten_energizer    one-cycle pulses when an item is eaten
//   i_rd_addr, o_rd_data              renderer read port, one-cycle latency
//   o_dots_left, o_dot_clear          remaining items / level cleared flag
module items_reloader
  import items_reloader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_items_reload,
  output logic              o_items_reload_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [CODE_W-1:0] i_rom_data,
  input  logic              i_eat_valid,
  input  logic [ADDR_W-1:0] i_eat_addr,
  output logic              o_eat_ready,
  output logic              o_eaten_dot,
  output logic              o_eaten_energizer,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [CODE_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_dots_left,
  output logic              o_dot_clear
);

  function automatic logic [ADDR_W-1:0] sat_dec(input logic [ADDR_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              rom_vld_q, rom_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] dots_q, dots_d;
  logic              eat_vld_p1_q, eat_vld_p1_d;
  logic              eat_vld_p2_q, eat_vld_p2_d;
  logic [ADDR_W-1:0] eat_addr_q, eat_addr_d;
  logic              eaten_dot_q, eaten_dot_d;
  logic              eaten_en_q, eaten_en_d;

  logic              reload_start;
  logic              eat_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [CODE_W-1:0] ram_wdata;
  logic [CODE_W-1:0] ram_rdata;

  items_ram u_ram (
    .i_clk     (i_clk),
    .i_a_addr  (ram_addr),
    .i_a_we    (ram_we),
    .i_a_wdata (ram_wdata),
    .o_a_rdata (ram_rdata),
    .i_b_addr  (i_rd_addr),
    .o_b_rdata (o_rd_data)
  );

  // A request is only honoured once the previous done has been withdrawn,
  // so a request still held high in DONE does not retrigger a fill.
  assign reload_start = i_items_reload && !done_q;
  assign eat_ready    = (state_q == ST_ACTIVE) && !eat_vld_p1_q && !eat_vld_p2_q;

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    addr_cnt_d   = addr_cnt_q;
    rom_vld_d    = 1'b0;
    wr_addr_d    = wr_addr_q;
    dots_d       = dots_q;
    eat_vld_p1_d = 1'b0;
    eat_vld_p2_d = 1'b0;
    eat_addr_d   = eat_addr_q;
    eaten_dot_d  = 1'b0;
    eaten_en_d   = 1'b0;
    ram_addr     = eat_addr_q;
    ram_we       = 1'b0;
    ram_wdata    = TILE_EMPTY;

    case (state_q)
      ST_IDLE: begin
        if (reload_start) begin
          state_d    = ST_FILL;
          addr_cnt_d = '0;
          dots_d     = '0;
        end
      end

      ST_FILL: begin
        // ROM data for the address issued last cycle lands now.
        if (rom_vld_q) begin
          ram_addr  = wr_addr_q;
          ram_we    = 1'b1;
          ram_wdata = i_rom_data;
          if (is_edible(i_rom_data)) begin
            dots_d = dots_q + 1'b1;
          end
        end
        if (addr_cnt_q < GRID_END) begin
          rom_vld_d  = 1'b1;
          wr_addr_d  = addr_cnt_q;
          addr_cnt_d = addr_cnt_q + 1'b1;
        end else if (!rom_vld_q) begin
          // Last write retired on the previous edge; the request level seen
          // now decides whether a done handshake is needed at all.
          addr_cnt_d = '0;
          if (i_items_reload) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end

      ST_DONE: begin
        if (!i_items_reload) begin
          state_d = ST_ACTIVE;
          done_d  = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (reload_start) begin
          // Any eat in flight is dropped; the map is about to be rewritten.
          state_d    = ST_FILL;
          addr_cnt_d = '0;
          dots_d     = '0;
        end else begin
          if (eat_vld_p1_q) begin
            eat_vld_p2_d = 1'b1;
          end
          if (eat_vld_p2_q && (eat_addr_q < GRID_END) && is_edible(ram_rdata)) begin
            ram_we      = 1'b1;
            ram_wdata   = TILE_EMPTY;
            dots_d      = sat_dec(dots_q);
            eaten_dot_d = (ram_rdata == TILE_DOT);
            eaten_en_d  = (ram_rdata == TILE_ENERGIZER);
          end
          if (i_eat_valid && eat_ready) begin
            eat_vld_p1_d = 1'b1;
            eat_addr_d   = i_eat_addr;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // p0 -> p1: accept eat / issue ROM address; p1 -> p2: RAM read returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      addr_cnt_q   <= '0;
      rom_vld_q    <= 1'b0;
      dots_q       <= '0;
      eat_vld_p1_q <= 1'b0;
      eat_vld_p2_q <= 1'b0;
      eaten_dot_q  <= 1'b0;
      eaten_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      addr_cnt_q   <= addr_cnt_d;
      rom_vld_q    <= rom_vld_d;
      dots_q       <= dots_d;
      eat_vld_p1_q <= eat_vld_p1_d;
      eat_vld_p2_q <= eat_vld_p2_d;
      eaten_dot_q  <= eaten_dot_d;
      eaten_en_q   <= eaten_en_d;
    end
  end

  // Address registers are only consumed under a valid flag, so no reset.
  always_ff @(posedge i_clk) begin
    wr_addr_q  <= wr_addr_d;
    eat_addr_q <= eat_addr_d;
  end

  assign o_items_reload_done = done_q;
  assign o_rom_addr          = addr_cnt_q;
  assign o_eat_ready         = eat_ready;
  assign o_eaten_dot         = eaten_dot_q;
  assign o_eaten_energizer   = eaten_en_q;
  assign o_dots_left         = dots_q;
  assign o_dot_clear         = (state_q == ST_ACTIVE) && (dots_q == '0);

endmodule

// File: tb/tb_items_reloader.sv
module tb_items_reloader;

  localparam int GSIZE = 868;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reload;
  logic       done;
  logic [9:0] rom_addr;
  logic [1:0] rom_data;
  logic       eat_valid;
  logic [9:0] eat_addr;
  logic       eat_ready;
  logic       eaten_dot;
  logic       eaten_en;
  logic [9:0] rd_addr;
  logic [1:0] rd_data;
  logic [9:0] dots_left;
  logic       dot_clear;

  logic [1:0] rom [1024];
  logic [1:0] model_map [GSIZE];
  int         en_pos;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // Item-map ROM: registered output, one-cycle latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  items_reloader dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_items_reload      (reload),
    .o_items_reload_done (done),
    .o_rom_addr          (rom_addr),
    .i_rom_data          (rom_data),
    .i_eat_valid         (eat_valid),
    .i_eat_addr          (eat_addr),
    .o_eat_ready         (eat_ready),
    .o_eaten_dot         (eaten_dot),
    .o_eaten_energizer   (eaten_en),
    .i_rd_addr           (rd_addr),
    .o_rd_data           (rd_data),
    .o_dots_left         (dots_left),
    .o_dot_clear         (dot_clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int count_edible();
    int c = 0;
    for (int i = 0; i < GSIZE; i++)
      if (model_map[i] == 2'b01 || model_map[i] == 2'b10) c++;
    return c;
  endfunction

  // Random empties (00 or 11), then nd dots (addr 29 first) and ne energizers
  // placed at distinct random positions.
  task automatic gen_rom(input int nd, input int ne);
    int p;
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    if (nd > 0) begin rom[29] = 2'b01; nd--; end
    while (nd > 0) begin
      p = $urandom_range(0, GSIZE - 1);
      if (rom[p] != 2'b01 && rom[p] != 2'b10) begin rom[p] = 2'b01; nd--; end
    end
    while (ne > 0) begin
      p = $urandom_range(0, GSIZE - 1);
      if (rom[p] != 2'b01 && rom[p] != 2'b10) begin rom[p] = 2'b10; en_pos = p; ne--; end
    end
  endtask

  task automatic load_model();
    for (int i = 0; i < GSIZE; i++) model_map[i] = rom[i];
  endtask

  task automatic ram_sweep(input string tag);
    int errs = 0;
    for (int i = 0; i <= GSIZE; i++) begin
      @(negedge clk);
      if (i > 0 && rd_data !== model_map[i-1]) errs++;
      if (i < GSIZE) rd_addr = 10'(i);
    end
    chk({tag, "_ram_vs_rom"}, 32'(errs), 0);
  endtask

  // Fill with the request held: done must rise 870 edges after the sampling edge.
  task automatic fill_expect_done(input string tag);
    int n = 0;
    @(negedge clk);
    reload = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk({tag, "_clear_on_fill"}, 32'(dot_clear), 0);
    end while (!done && n < 1000);
    chk({tag, "_done_latency"}, 32'(n - 1), 870);
    load_model();
    chk({tag, "_dots"}, 32'(dots_left), 32'(count_edible()));
    ram_sweep(tag);
    chk({tag, "_done_held"}, 32'(done), 1);
    reload = 1'b0;
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 0);
    chk({tag, "_ready_active"}, 32'(eat_ready), 1);
    chk({tag, "_clear_active"}, 32'(dot_clear), 32'(count_edible() == 0));
  endtask

  // Fill with the request withdrawn mid-fill: straight to ACTIVE, no done.
  task automatic fill_no_done(input string tag);
    int n = 0;
    bit seen_done = 1'b0;
    @(negedge clk);
    reload = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 6) reload = 1'b0;
      if (n == 300) reload = 1'b1;
      if (n == 302) reload = 1'b0;
      seen_done |= done;
    end while (!eat_ready && n < 1000);
    chk({tag, "_active_latency"}, 32'(n - 1), 870);
    chk({tag, "_no_done"}, 32'(seen_done), 0);
    load_model();
    chk({tag, "_dots"}, 32'(dots_left), 32'(count_edible()));
    ram_sweep(tag);
  endtask

  task automatic do_eat(input logic [9:0] a, input string tag);
    int waited = 0;
    int ndot = 0;
    int nen = 0;
    logic [1:0] code;
    while (!eat_ready && waited < 20) begin @(negedge clk); waited++; end
    chk({tag, "_ready"}, 32'(eat_ready), 1);
    eat_valid = 1'b1;
    eat_addr  = a;
    @(negedge clk);
    eat_valid = 1'b0;
    chk({tag, "_busy"}, 32'(eat_ready), 0);
    repeat (4) begin
      ndot += 32'(eaten_dot);
      nen  += 32'(eaten_en);
      @(negedge clk);
    end
    code = (a < GSIZE) ? model_map[a] : 2'b00;
    chk({tag, "_dot_pulses"}, 32'(ndot), 32'(code == 2'b01));
    chk({tag, "_en_pulses"}, 32'(nen), 32'(code == 2'b10));
    if (code == 2'b01 || code == 2'b10) model_map[a] = 2'b00;
    chk({tag, "_dots_left"}, 32'(dots_left), 32'(count_edible()));
    chk({tag, "_clear"}, 32'(dot_clear), 32'(count_edible() == 0));
    if (a < GSIZE) begin
      rd_addr = a;
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_tile"}, 32'(rd_data), 32'(model_map[a]));
    end
  endtask

  initial begin
    int n;
    int ndot;
    rst_n = 1'b0; reload = 1'b0; eat_valid = 1'b0; eat_addr = '0; rd_addr = '0;
    en_pos = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_ready", 32'(eat_ready), 0);
    chk("rst_dot_pulse", 32'(eaten_dot), 0);
    chk("rst_en_pulse", 32'(eaten_en), 0);
    chk("rst_dots_left", 32'(dots_left), 0);
    chk("rst_clear", 32'(dot_clear), 0);
    rst_n = 1'b1;

    // Eat requests in IDLE are ignored.
    eat_valid = 1'b1; eat_addr = 10'd29;
    ndot = 0;
    repeat (4) begin @(negedge clk); ndot += 32'(eaten_dot) + 32'(eaten_en); end
    eat_valid = 1'b0;
    chk("idle_eat_pulses", 32'(ndot), 0);
    chk("idle_ready", 32'(eat_ready), 0);

    // Full map: 240 dots + 4 energizers.
    gen_rom(240, 4);
    fill_expect_done("fillA");
    chk("fillA_244", 32'(dots_left), 244);
    do_eat(10'd29, "eat29_first");
    chk("eat29_first_243", 32'(dots_left), 243);
    do_eat(10'd29, "eat29_again");
    chk("eat29_again_243", 32'(dots_left), 243);
    do_eat(10'(en_pos), "eat_en_A");
    for (int k = 0; k < 6; k++)
      do_eat(10'($urandom_range(0, (k == 5) ? 1023 : GSIZE - 1)), "eat_rand");

    // Single energizer map, request dropped mid-fill.
    gen_rom(0, 1);
    fill_no_done("fillB");
    chk("fillB_1", 32'(dots_left), 1);
    do_eat(10'(en_pos), "eat_only_en");
    chk("eat_only_en_clear", 32'(dot_clear), 1);
    do_eat(10'd900, "eat_oob");
    chk("eat_oob_clear", 32'(dot_clear), 1);
    chk("eat_oob_zero", 32'(dots_left), 0);
    do_eat(10'(en_pos), "eat_en_again");

    // Next level from a cleared board.
    gen_rom(240, 4);
    fill_expect_done("fillC");
    chk("fillC_244", 32'(dots_left), 244);

    // Reset in the middle of a fill.
    gen_rom(100, 7);
    @(negedge clk);
    reload = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rom_addr != 10'd400 && n < 1000);
    chk("midfill_reached_400", 32'(rom_addr), 400);
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_done", 32'(done), 0);
    chk("midfill_rst_rom_addr", 32'(rom_addr), 0);
    chk("midfill_rst_dots", 32'(dots_left), 0);
    chk("midfill_rst_ready", 32'(eat_ready), 0);
    reload = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndot = 0;
    repeat (5) begin @(negedge clk); ndot += 32'(done) + 32'(eaten_dot) + 32'(eaten_en); end
    chk("midfill_quiet", 32'(ndot), 0);
    fill_expect_done("fillD");
    chk("fillD_107", 32'(dots_left), 107);
    do_eat(10'd29, "eat29_D");
    do_eat(10'(en_pos), "eat_en_D");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/items_reloader.md
ITEMS_RELOADER -- requirements
Module: items_reloader

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have i_items_reload  in  1  reload request, level, held high by the game controller until done is seen.
REQ-003 SHALL have o_items_reload_done  out  1  reload complete, level.
REQ-004 SHALL have o_rom_addr  out  10  initial item-map ROM address; i_rom_data  in  2  ROM tile code, one-cycle latency.
REQ-005 SHALL have i_eat_valid  in  1, i_eat_addr  in  10, o_eat_ready  out  1  pacman eat request handshake.
REQ-006 SHALL have o_eaten_dot  out  1, o_eaten_energizer  out  1  single-cycle eat pulses.
REQ-007 SHALL have i_rd_addr  in  10, o_rd_data  out  2  renderer read port, one-cycle latency.
REQ-008 SHALL have o_dots_left  out  10  remaining edible items; o_dot_clear  out  1  all items eaten.

Function
REQ-009 Grid SHALL be 28x31 = 868 tiles, linear address 0..867; codes 00 empty, 01 dot, 10 energizer, 11 treated as empty.
REQ-010 States SHALL be IDLE, FILL, DONE, ACTIVE.
REQ-011 IDLE/ACTIVE/DONE: i_items_reload sampled high while done is low -> FILL, address counter 0, dot counter 0.
REQ-012 FILL: o_rom_addr = counter, increments 0..867 once per cycle; data returned one cycle later SHALL be written to RAM[counter-1]; each 01/10 code increments dot counter.
REQ-013 o_items_reload_done SHALL rise exactly 870 clock edges after the edge that sampled the request (868 addresses + 1 ROM latency + 1 register) and state -> DONE.
REQ-014 DONE: done held high until i_items_reload sampled low; then done low next cycle, state -> ACTIVE.
REQ-015 If i_items_reload is already low when FILL completes, SHALL go directly to ACTIVE with done never asserted.
REQ-016 FILL always runs to completion; request changes during FILL SHALL be ignored.
REQ-017 o_eat_ready SHALL be high only in ACTIVE with no eat in flight; an eat is accepted when i_eat_valid && o_eat_ready.
REQ-018 Eat SHALL be read-modify-write: cycle+1 read RAM[addr]; cycle+2 if 01/10 write 00, decrement o_dots_left, pulse o_eaten_dot or o_eaten_energizer; ready low during both cycles.
REQ-019 Eat of empty tile or addr >= 868 SHALL produce no write, no pulse, no count change.
REQ-020 o_dots_left SHALL saturate at 0, never wrap.
REQ-021 o_dot_clear SHALL equal (state == ACTIVE) && (o_dots_left == 0), combinational from registers.
REQ-022 Renderer read port SHALL be independent of fill/eat; read of a tile written same cycle returns the old value.
REQ-023 i_eat_valid outside ACTIVE SHALL be ignored (not queued).

Reset
REQ-024 Reset SHALL force state IDLE, done 0, o_rom_addr 0, o_eat_ready 0, eat pulses 0, o_dots_left 0, o_dot_clear 0.
REQ-025 RAM contents are not reset; they are undefined until the first FILL completes.
REQ-026 Reset asserted mid-FILL or mid-eat SHALL abort immediately; no partial done or pulse after release.

Structure
REQ-027 Tile codes, grid width/height/size constants and the state enum SHALL live in the shared params package.
REQ-028 Item storage SHALL be sub-module items_ram: 868x2, one synchronous write/read port plus one synchronous read port.

Verification
REQ-029 ROM with 240 dots + 4 energizers, pulse reload high -> done high at edge 870, o_dots_left = 244, RAM equals ROM.
REQ-030 Drop reload after done -> done low next cycle, ACTIVE, o_eat_ready high, o_dot_clear 0.
REQ-031 Eat addr 29 (dot) then again addr 29 -> first: one o_eaten_dot pulse, count 243; second: no pulse, count 243.
REQ-032 ROM with 1 energizer only, eat it -> o_eaten_energizer pulse, o_dots_left 0, o_dot_clear 1; eat addr 900 -> no effect.
REQ-033 Reset asserted at FILL address 400, released, reload raised -> full 870-cycle fill, correct count, no spurious done.
REQ-034 Reload from ACTIVE with count 0 (next level) -> o_dot_clear drops on FILL entry, refill restores count 244.
